// File: rtl/arm_pipeline_pkg.sv
// Shared types and constants for the ARM five-stage pipeline hazard controller.
package arm_pipeline_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'b00,
        ST_MEM_WAIT = 2'b01,
        ST_HALT     = 2'b10
    } hz_state_t;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_t;

    localparam logic [3:0] PC_REG = 4'd15;

endpackage

// File: rtl/arm_hazard_forward_unit.sv
// EX-stage forwarding select for one source operand: Memory-stage result wins over
// Writeback-stage result; the PC register is never forwarded.
module arm_hazard_forward_unit
    import arm_pipeline_pkg::*;
#(
    parameter int RegAddrWidth = 4
) (
    input  logic [RegAddrWidth-1:0] i_RAE,
    input  logic [RegAddrWidth-1:0] i_WA3M,
    input  logic                    i_RegWriteM,
    input  logic [RegAddrWidth-1:0] i_WA3W,
    input  logic                    i_RegWriteW,
    output fwd_sel_t                o_Forward
);

    logic not_pc;

    assign not_pc = (i_RAE != RegAddrWidth'(PC_REG));

    always_comb begin
        o_Forward = FWD_RF;
        if (i_RegWriteM && (i_WA3M == i_RAE) && not_pc) begin
            o_Forward = FWD_MEM;
        end else if (i_RegWriteW && (i_WA3W == i_RAE) && not_pc) begin
            o_Forward = FWD_WB;
        end
    end

endmodule

// File: rtl/arm_pipeline_hazard_ctrl.sv
// Pipeline stall/flush/forward controller for the five-stage ARM datapath.
// Optional saturating perf counters are built when HAZARD_PERF_CNT_EN is defined.
module arm_pipeline_hazard_ctrl
    import arm_pipeline_pkg::*;
#(
    parameter int RegAddrWidth = 4,
    parameter int MemWaitMax   = 15,
    parameter int CntWidth     = 16
) (
    input  logic                    i_CLK,
    input  logic                    i_RESET,
    input  logic [RegAddrWidth-1:0] i_RA1D,
    input  logic [RegAddrWidth-1:0] i_RA2D,
    input  logic [RegAddrWidth-1:0] i_RA1E,
    input  logic [RegAddrWidth-1:0] i_RA2E,
    input  logic [RegAddrWidth-1:0] i_WA3E,
    input  logic                    i_MemToRegE,
    input  logic [RegAddrWidth-1:0] i_WA3M,
    input  logic                    i_RegWriteM,
    input  logic [RegAddrWidth-1:0] i_WA3W,
    input  logic                    i_RegWriteW,
    input  logic                    i_BranchTakenE,
    input  logic                    i_MemReqM,
    input  logic                    i_MemReadyM,
    output logic                    o_StallF,
    output logic                    o_StallD,
    output logic                    o_StallE,
    output logic                    o_StallM,
    output logic                    o_FlushD,
    output logic                    o_FlushE,
    output logic                    o_FlushW,
    output logic [1:0]              o_ForwardAE,
    output logic [1:0]              o_ForwardBE,
    output logic                    o_MemErr,
    output logic [CntWidth-1:0]     o_StallCycles,
    output logic [CntWidth-1:0]     o_FlushCount,
    output hz_state_t               o_State
);

    hz_state_t             state, state_next;
    logic [CntWidth-1:0]   wait_cnt, wait_cnt_next;
    fwd_sel_t              fwd_a, fwd_b;
    logic                  load_use;
    logic                  apply_rules;
    logic                  stall_f, stall_d, stall_e, stall_m;
    logic                  flush_d, flush_e, flush_w;

    arm_hazard_forward_unit #(.RegAddrWidth(RegAddrWidth)) u_fwd_a (
        .i_RAE       (i_RA1E),
        .i_WA3M      (i_WA3M),
        .i_RegWriteM (i_RegWriteM),
        .i_WA3W      (i_WA3W),
        .i_RegWriteW (i_RegWriteW),
        .o_Forward   (fwd_a)
    );

    arm_hazard_forward_unit #(.RegAddrWidth(RegAddrWidth)) u_fwd_b (
        .i_RAE       (i_RA2E),
        .i_WA3M      (i_WA3M),
        .i_RegWriteM (i_RegWriteM),
        .i_WA3W      (i_WA3W),
        .i_RegWriteW (i_RegWriteW),
        .o_Forward   (fwd_b)
    );

    assign load_use = i_MemToRegE && ((i_WA3E == i_RA1D) || (i_WA3E == i_RA2D));

    always_ff @(posedge i_CLK or posedge i_RESET) begin
        if (i_RESET) begin
            state    <= ST_RUN;
            wait_cnt <= '0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_cnt_next;
        end
    end

    always_comb begin
        state_next    = state;
        wait_cnt_next = wait_cnt;
        apply_rules   = 1'b0;
        stall_f = 1'b0; stall_d = 1'b0; stall_e = 1'b0; stall_m = 1'b0;
        flush_d = 1'b0; flush_e = 1'b0; flush_w = 1'b0;
        case (state)
            ST_RUN: begin
                if (i_MemReqM && !i_MemReadyM) begin
                    stall_f = 1'b1; stall_d = 1'b1; stall_e = 1'b1; stall_m = 1'b1;
                    flush_w       = 1'b1;
                    state_next    = ST_MEM_WAIT;
                    wait_cnt_next = CntWidth'(1);
                end else begin
                    apply_rules = 1'b1;
                end
            end
            ST_MEM_WAIT: begin
                if (i_MemReadyM) begin
                    apply_rules   = 1'b1;
                    state_next    = ST_RUN;
                    wait_cnt_next = '0;
                end else begin
                    stall_f = 1'b1; stall_d = 1'b1; stall_e = 1'b1; stall_m = 1'b1;
                    flush_w = 1'b1;
                    if (wait_cnt == CntWidth'(MemWaitMax)) begin
                        state_next = ST_HALT;
                    end else begin
                        wait_cnt_next = wait_cnt + CntWidth'(1);
                    end
                end
            end
            ST_HALT: begin
                stall_f = 1'b1; stall_d = 1'b1; stall_e = 1'b1; stall_m = 1'b1;
                flush_w = 1'b1;
            end
            default: state_next = ST_RUN;
        endcase
        // Execute inputs are only trusted when the pipe is moving; a taken branch squashes the load-use stall.
        if (apply_rules) begin
            if (load_use) begin
                stall_f = 1'b1; stall_d = 1'b1; flush_e = 1'b1;
            end
            if (i_BranchTakenE) begin
                flush_d = 1'b1; flush_e = 1'b1;
                stall_f = 1'b0; stall_d = 1'b0;
            end
        end
    end

    always_comb begin
        o_StallF    = stall_f;
        o_StallD    = stall_d;
        o_StallE    = stall_e;
        o_StallM    = stall_m;
        o_FlushD    = flush_d;
        o_FlushE    = flush_e;
        o_FlushW    = flush_w;
        o_ForwardAE = fwd_a;
        o_ForwardBE = fwd_b;
        if (i_RESET) begin
            o_StallF = 1'b0; o_StallD = 1'b0; o_StallE = 1'b0; o_StallM = 1'b0;
            o_FlushD = 1'b1; o_FlushE = 1'b1; o_FlushW = 1'b1;
            o_ForwardAE = FWD_RF;
            o_ForwardBE = FWD_RF;
        end
    end

    assign o_MemErr = (state == ST_HALT);
    assign o_State  = state;

`ifdef HAZARD_PERF_CNT_EN
    logic [CntWidth-1:0] stall_cycles, flush_count;
    logic                any_stall, any_flush;

    assign any_stall = o_StallF | o_StallD | o_StallE | o_StallM;
    assign any_flush = o_FlushD | o_FlushE;

    always_ff @(posedge i_CLK or posedge i_RESET) begin
        if (i_RESET) begin
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            if (any_stall && (stall_cycles != '1)) stall_cycles <= stall_cycles + CntWidth'(1);
            if (any_flush && (flush_count != '1))  flush_count  <= flush_count + CntWidth'(1);
        end
    end

    assign o_StallCycles = stall_cycles;
    assign o_FlushCount  = flush_count;
`else
    assign o_StallCycles = '0;
    assign o_FlushCount  = '0;
`endif

endmodule

// File: tb/tb_arm_pipeline_hazard_ctrl.sv
// Directed self-checking bench for arm_pipeline_hazard_ctrl (default parameters).
module tb_arm_pipeline_hazard_ctrl;
    import arm_pipeline_pkg::*;

`ifdef HAZARD_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  ra1d, ra2d, ra1e, ra2e, wa3e, wa3m, wa3w;
    logic        memtorege, regwritem, regwritew, branch, memreq, memready;
    logic        stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w, memerr;
    logic [1:0]  fwd_a, fwd_b;
    logic [15:0] stall_cycles, flush_count;
    hz_state_t   state;
    logic [3:0]  stalls;
    logic [2:0]  flushes;
    int          checks = 0;
    int          failures = 0;

    assign stalls  = {stall_f, stall_d, stall_e, stall_m};
    assign flushes = {flush_d, flush_e, flush_w};

    always #5 clk = ~clk;

    arm_pipeline_hazard_ctrl dut (
        .i_CLK(clk), .i_RESET(rst),
        .i_RA1D(ra1d), .i_RA2D(ra2d), .i_RA1E(ra1e), .i_RA2E(ra2e), .i_WA3E(wa3e),
        .i_MemToRegE(memtorege), .i_WA3M(wa3m), .i_RegWriteM(regwritem),
        .i_WA3W(wa3w), .i_RegWriteW(regwritew), .i_BranchTakenE(branch),
        .i_MemReqM(memreq), .i_MemReadyM(memready),
        .o_StallF(stall_f), .o_StallD(stall_d), .o_StallE(stall_e), .o_StallM(stall_m),
        .o_FlushD(flush_d), .o_FlushE(flush_e), .o_FlushW(flush_w),
        .o_ForwardAE(fwd_a), .o_ForwardBE(fwd_b), .o_MemErr(memerr),
        .o_StallCycles(stall_cycles), .o_FlushCount(flush_count), .o_State(state)
    );

    task automatic clear_inputs();
        ra1d = 4'd0; ra2d = 4'd0; ra1e = 4'd0; ra2e = 4'd0; wa3e = 4'd0;
        wa3m = 4'd0; wa3w = 4'd0; memtorege = 1'b0; regwritem = 1'b0; regwritew = 1'b0;
        branch = 1'b0; memreq = 1'b0; memready = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        clear_inputs();
        regwritem = 1'b1; wa3m = 4'd3; ra1e = 4'd3; ra2e = 4'd3;
        rst = 1'b1;
        #2;
        checks++; if (stalls !== 4'b0000) begin failures++; $display("FAIL reset_stalls got=%b exp=0000", stalls); end
        checks++; if (flushes !== 3'b111) begin failures++; $display("FAIL reset_flushes got=%b exp=111", flushes); end
        checks++; if ({fwd_a, fwd_b} !== 4'b0000) begin failures++; $display("FAIL reset_fwd got=%b exp=0000", {fwd_a, fwd_b}); end
        checks++; if (memerr !== 1'b0 || state !== ST_RUN) begin failures++; $display("FAIL reset_state got=%0d/%b exp=0/0", state, memerr); end
        checks++; if (stall_cycles !== 16'd0 || flush_count !== 16'd0) begin failures++; $display("FAIL reset_perf got=%0d/%0d exp=0/0", stall_cycles, flush_count); end
        tick(); tick();
        rst = 1'b0;
        clear_inputs();
        #2;
        checks++; if ({stalls, flushes} !== 7'b0) begin failures++; $display("FAIL idle_ctrl got=%b exp=0000000", {stalls, flushes}); end
    endtask

    task automatic test_forward();
        // {regwritem, wa3m, regwritew, wa3w, ra1e, ra2e, exp_a, exp_b}
        logic [25:0] vec [7];
        vec[0] = {1'b1, 4'd3,  1'b1, 4'd3,  4'd3,  4'd4, 2'b10, 2'b00};
        vec[1] = {1'b1, 4'd3,  1'b1, 4'd3,  4'd15, 4'd3, 2'b00, 2'b10};
        vec[2] = {1'b1, 4'd15, 1'b1, 4'd15, 4'd15, 4'd15, 2'b00, 2'b00};
        vec[3] = {1'b0, 4'd3,  1'b1, 4'd3,  4'd3,  4'd3, 2'b01, 2'b01};
        vec[4] = {1'b1, 4'd7,  1'b1, 4'd3,  4'd7,  4'd3, 2'b10, 2'b01};
        vec[5] = {1'b1, 4'd5,  1'b0, 4'd5,  4'd5,  4'd6, 2'b10, 2'b00};
        vec[6] = {1'b0, 4'd9,  1'b0, 4'd9,  4'd9,  4'd9, 2'b00, 2'b00};
        for (int i = 0; i < 7; i++) begin
            clear_inputs();
            {regwritem, wa3m, regwritew, wa3w, ra1e, ra2e} = vec[i][25:4];
            #2;
            checks++;
            if ({fwd_a, fwd_b} !== vec[i][3:0]) begin
                failures++;
                $display("FAIL fwd_vec%0d got=%b exp=%b", i, {fwd_a, fwd_b}, vec[i][3:0]);
            end
            tick();
        end
        clear_inputs();
    endtask

    task automatic test_load_use();
        clear_inputs();
        memtorege = 1'b1; wa3e = 4'd5; ra1d = 4'd1; ra2d = 4'd5;
        #2;
        checks++; if (stalls !== 4'b1100) begin failures++; $display("FAIL lu_rb_stalls got=%b exp=1100", stalls); end
        checks++; if (flushes !== 3'b010) begin failures++; $display("FAIL lu_rb_flushes got=%b exp=010", flushes); end
        tick();
        clear_inputs();
        memreq = 1'b1; memready = 1'b1;
        #2;
        checks++; if ({stalls, flushes} !== 7'b0) begin failures++; $display("FAIL lu_after got=%b exp=0000000", {stalls, flushes}); end
        tick();
        clear_inputs();
        memtorege = 1'b1; wa3e = 4'd8; ra1d = 4'd8; ra2d = 4'd2;
        #2;
        checks++; if ({stalls, flushes} !== 7'b1100010) begin failures++; $display("FAIL lu_ra_ctrl got=%b exp=1100010", {stalls, flushes}); end
        memtorege = 1'b0;
        #1;
        checks++; if ({stalls, flushes} !== 7'b0) begin failures++; $display("FAIL nonload_ctrl got=%b exp=0000000", {stalls, flushes}); end
        tick();
        clear_inputs();
    endtask

    task automatic test_branch_override();
        logic [15:0] f0;
        clear_inputs();
        f0 = flush_count;
        memtorege = 1'b1; wa3e = 4'd5; ra2d = 4'd5; branch = 1'b1;
        #2;
        checks++; if (stalls !== 4'b0000) begin failures++; $display("FAIL br_stalls got=%b exp=0000", stalls); end
        checks++; if (flushes !== 3'b110) begin failures++; $display("FAIL br_flushes got=%b exp=110", flushes); end
        tick();
        clear_inputs();
        #1;
        checks++;
        if (flush_count !== (PERF ? f0 + 16'd1 : 16'd0)) begin
            failures++; $display("FAIL br_flush_count got=%0d exp=%0d", flush_count, PERF ? f0 + 16'd1 : 16'd0);
        end
    endtask

    task automatic test_mem_wait(input int n, input logic br);
        logic [15:0] s0;
        clear_inputs();
        s0 = stall_cycles;
        memreq = 1'b1; memready = 1'b0; branch = br;
        memtorege = br; wa3e = 4'd2; ra1d = 4'd2;
        for (int i = 0; i < n; i++) begin
            #1;
            checks++;
            if ({stalls, flushes} !== 7'b1111001) begin
                failures++; $display("FAIL wait%0d_cyc%0d got=%b exp=1111001", n, i, {stalls, flushes});
            end
            tick();
        end
        checks++; if (state !== ST_MEM_WAIT) begin failures++; $display("FAIL wait%0d_state got=%0d exp=1", n, state); end
        memready = 1'b1;
        #1;
        checks++;
        if ({stalls, flushes} !== (br ? 7'b0000110 : 7'b0000000)) begin
            failures++; $display("FAIL wait%0d_release got=%b exp=%b", n, {stalls, flushes}, br ? 7'b0000110 : 7'b0000000);
        end
        tick();
        clear_inputs();
        #1;
        checks++; if (state !== ST_RUN || memerr !== 1'b0) begin failures++; $display("FAIL wait%0d_run got=%0d/%b exp=0/0", n, state, memerr); end
        checks++;
        if (stall_cycles !== (PERF ? s0 + 16'(n) : 16'd0)) begin
            failures++; $display("FAIL wait%0d_stall_cycles got=%0d exp=%0d", n, stall_cycles, PERF ? s0 + 16'(n) : 16'd0);
        end
    endtask

    task automatic test_zero_wait();
        clear_inputs();
        memreq = 1'b1; memready = 1'b1;
        #2;
        checks++; if (stalls !== 4'b0000 || flush_w !== 1'b0) begin failures++; $display("FAIL zw_ctrl got=%b/%b exp=0000/0", stalls, flush_w); end
        tick();
        checks++; if (state !== ST_RUN) begin failures++; $display("FAIL zw_state got=%0d exp=0", state); end
        clear_inputs();
    endtask

    task automatic test_halt();
        clear_inputs();
        memreq = 1'b1; memready = 1'b0;
        for (int i = 0; i < 16; i++) tick();
        checks++; if (state !== ST_HALT || memerr !== 1'b1) begin failures++; $display("FAIL halt_enter got=%0d/%b exp=2/1", state, memerr); end
        memready = 1'b1; memreq = 1'b0;
        tick(); tick(); tick();
        checks++; if (memerr !== 1'b1 || {stalls, flushes} !== 7'b1111001) begin failures++; $display("FAIL halt_sticky got=%b/%b exp=1/1111001", memerr, {stalls, flushes}); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        clear_inputs();
        #1;
        checks++; if (state !== ST_RUN || memerr !== 1'b0 || {stalls, flushes} !== 7'b0) begin failures++; $display("FAIL halt_reset got=%0d/%b/%b exp=0/0/0000000", state, memerr, {stalls, flushes}); end
        checks++; if (stall_cycles !== 16'd0 || flush_count !== 16'd0) begin failures++; $display("FAIL halt_reset_perf got=%0d/%0d exp=0/0", stall_cycles, flush_count); end
        // Timeout boundary: 15 not-ready cycles still releases normally.
        memreq = 1'b1; memready = 1'b0;
        for (int i = 0; i < 15; i++) tick();
        memready = 1'b1;
        #1;
        checks++; if (stalls !== 4'b0000) begin failures++; $display("FAIL bound15_release got=%b exp=0000", stalls); end
        tick();
        clear_inputs();
        checks++; if (state !== ST_RUN || memerr !== 1'b0) begin failures++; $display("FAIL bound15_state got=%0d/%b exp=0/0", state, memerr); end
        // Reset in the middle of a wait.
        memreq = 1'b1; memready = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        rst = 1'b1;
        #2;
        checks++; if ({stalls, flushes} !== 7'b0000111) begin failures++; $display("FAIL midwait_rst got=%b exp=0000111", {stalls, flushes}); end
        tick();
        rst = 1'b0;
        clear_inputs();
        #1;
        checks++; if (state !== ST_RUN || {stalls, flushes} !== 7'b0) begin failures++; $display("FAIL midwait_after got=%0d/%b exp=0/0000000", state, {stalls, flushes}); end
    endtask

    initial begin
        test_reset();
        test_forward();
        test_load_use();
        test_branch_override();
        test_mem_wait(3, 1'b0);
        test_mem_wait(2, 1'b1);
        test_zero_wait();
        test_halt();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
